// File: rtl/risc_control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the 8-bit accumulator datapath.
// Produces the register/memory control word and bus select from state and opcode.
module risc_control_sequencer #(
  parameter logic [3:0] HALT_OPCODE = 4'hF,
  parameter logic [2:0] IDLE_SEL    = 3'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [3:0]  instruction,
  output logic [23:0] reg_mem_ctrl,
  output logic [2:0]  bus_ctrl,
  output logic        halted,
  output logic [2:0]  state,
  output logic [7:0]  instr_count
);

  typedef enum logic [2:0] {
    S_FETCH0 = 3'd0,
    S_FETCH1 = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC0  = 3'd3,
    S_EXEC1  = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Field base bits; within a field: +0 load, +1 inc, +2 clear.
  localparam int AR_LSB  = 3;
  localparam int PC_LSB  = 6;
  localparam int DR_LSB  = 9;
  localparam int AC_LSB  = 12;
  localparam int IR_LSB  = 15;
  localparam int MEM_RD  = 21;
  localparam int MEM_WR  = 22;
  localparam int F_LOAD  = 0;
  localparam int F_INC   = 1;
  localparam int F_CLR   = 2;

  localparam logic [2:0] BUS_AR  = 3'd1;
  localparam logic [2:0] BUS_PC  = 3'd2;
  localparam logic [2:0] BUS_AC  = 3'd4;
  localparam logic [2:0] BUS_IR  = 3'd5;
  localparam logic [2:0] BUS_MEM = 3'd7;

  localparam logic [23:0] RESET_WORD = 24'h104920;

  localparam logic [3:0] OP_STA = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_INA = 4'h8;
  localparam logic [3:0] OP_CLA = 4'h9;

  state_t      state_q, state_d;
  logic [7:0]  count_q;
  logic        retire;
  logic        is_halt_op;
  logic        needs_operand;
  logic [23:0] ctrl;
  logic [2:0]  bus_sel;
  logic        halted_w;

  assign is_halt_op    = (instruction == HALT_OPCODE);
  assign needs_operand = instruction inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6};

  always_comb begin
    state_d = S_FETCH0;
    retire  = 1'b0;
    case (state_q)
      S_FETCH0: state_d = run ? S_FETCH1 : S_FETCH0;
      S_FETCH1: state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC0;
      S_EXEC0: begin
        if (is_halt_op) begin
          state_d = S_HALT;
          retire  = 1'b1;
        end else if (needs_operand) begin
          state_d = S_EXEC1;
        end else begin
          state_d = S_FETCH0;
          retire  = 1'b1;
        end
      end
      S_EXEC1: retire = 1'b1;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH0;
    endcase
  end

  // Reset forces the clear word regardless of state so the datapath clears on the same edge.
  always_comb begin
    ctrl     = '0;
    bus_sel  = IDLE_SEL;
    halted_w = 1'b0;
    if (rst) begin
      ctrl = RESET_WORD;
    end else begin
      case (state_q)
        S_FETCH0: begin
          if (run) begin
            bus_sel              = BUS_PC;
            ctrl[AR_LSB+F_LOAD]  = 1'b1;
          end
        end
        S_FETCH1: begin
          bus_sel              = BUS_MEM;
          ctrl[MEM_RD]         = 1'b1;
          ctrl[IR_LSB+F_LOAD]  = 1'b1;
          ctrl[PC_LSB+F_INC]   = 1'b1;
        end
        S_DECODE: begin
          bus_sel              = BUS_IR;
          ctrl[AR_LSB+F_LOAD]  = 1'b1;
        end
        S_EXEC0: begin
          if (is_halt_op) begin
            ctrl = '0;
          end else if (needs_operand) begin
            bus_sel              = BUS_MEM;
            ctrl[MEM_RD]         = 1'b1;
            ctrl[DR_LSB+F_LOAD]  = 1'b1;
          end else begin
            case (instruction)
              OP_STA: begin
                bus_sel      = BUS_AC;
                ctrl[MEM_WR] = 1'b1;
              end
              OP_JMP: begin
                bus_sel              = BUS_AR;
                ctrl[PC_LSB+F_LOAD]  = 1'b1;
              end
              OP_INA:  ctrl[AC_LSB+F_INC] = 1'b1;
              OP_CLA:  ctrl[AC_LSB+F_CLR] = 1'b1;
              default: ctrl = '0;
            endcase
          end
        end
        S_EXEC1: ctrl[AC_LSB+F_LOAD] = 1'b1;
        S_HALT:  halted_w = 1'b1;
        default: ctrl = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        count_q <= count_q + 8'd1;
      end
    end
  end

  assign reg_mem_ctrl = ctrl;
  assign bus_ctrl     = bus_sel;
  assign halted       = halted_w;
  assign state        = state_q;
  assign instr_count  = count_q;

endmodule

// File: tb/tb_risc_control_sequencer.sv
// Bench: the sequencer drives a behavioural datapath; results are compared with an
// instruction-level interpreter of the accumulator ISA.
module tb_risc_control_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [3:0]  instruction;
  logic [23:0] reg_mem_ctrl;
  logic [2:0]  bus_ctrl;
  logic        halted;
  logic [2:0]  state;
  logic [7:0]  instr_count;

  risc_control_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .instruction  (instruction),
    .reg_mem_ctrl (reg_mem_ctrl),
    .bus_ctrl     (bus_ctrl),
    .halted       (halted),
    .state        (state),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural datapath ----------------
  logic [7:0] mem [16];
  logic [7:0] prog [16];
  logic [3:0] ar, pc;
  logic [7:0] dr, ac, ir, tr;
  logic [7:0] bus;
  logic       poke = 1'b0;
  logic [7:0] poke_val = 8'h00;

  assign instruction = ir[7:4];

  always_comb begin
    bus = 8'h00;
    case (bus_ctrl)
      3'd1: bus = {4'h0, ar};
      3'd2: bus = {4'h0, pc};
      3'd3: bus = dr;
      3'd4: bus = ac;
      3'd5: bus = ir;
      3'd6: bus = tr;
      3'd7: bus = mem[ar];
      default: bus = 8'h00;
    endcase
  end

  function automatic logic [3:0] nxt4(input logic [3:0] v, input logic [2:0] f, input logic [3:0] d);
    return f[2] ? 4'h0 : f[1] ? v + 4'h1 : f[0] ? d : v;
  endfunction

  function automatic logic [7:0] nxt8(input logic [7:0] v, input logic [2:0] f, input logic [7:0] d);
    return f[2] ? 8'h00 : f[1] ? v + 8'h01 : f[0] ? d : v;
  endfunction

  function automatic logic [7:0] alu_f(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] d);
    case (sel)
      3'd0:    return a + d;
      3'd1:    return {d[6:0], 1'b0};
      3'd2:    return ~(a ^ d);
      3'd3:    return {d[7], d[7:1]};
      3'd6:    return 8'h00 - d;
      default: return d;
    endcase
  endfunction

  always @(posedge clk) begin
    if (poke) begin
      for (int i = 0; i < 16; i++) mem[i] <= prog[i];
      ar <= poke_val[3:0];
      pc <= poke_val[7:4];
      dr <= poke_val;
      ac <= ~poke_val;
      ir <= poke_val ^ 8'h5A;
      tr <= poke_val + 8'h01;
    end else begin
      if (reg_mem_ctrl[22]) mem[ar] <= bus;
      ar <= nxt4(ar, reg_mem_ctrl[5:3], bus[3:0]);
      pc <= nxt4(pc, reg_mem_ctrl[8:6], bus[3:0]);
      dr <= nxt8(dr, reg_mem_ctrl[11:9], bus);
      ac <= nxt8(ac, reg_mem_ctrl[14:12], alu_f(ir[6:4], ac, dr));
      if (reg_mem_ctrl[15]) ir <= bus;
      tr <= nxt8(tr, reg_mem_ctrl[20:18], bus);
    end
  end

  // Control word must be well formed in every cycle.
  always @(negedge clk) begin
    logic [7:0] viol;
    viol    = '0;
    viol[0] = |reg_mem_ctrl[2:0];
    viol[1] = reg_mem_ctrl[23];
    viol[2] = |reg_mem_ctrl[17:16];
    viol[3] = !$onehot0(reg_mem_ctrl[5:3]);
    viol[4] = !$onehot0(reg_mem_ctrl[8:6]);
    viol[5] = !$onehot0(reg_mem_ctrl[11:9]);
    viol[6] = !$onehot0(reg_mem_ctrl[14:12]);
    viol[7] = !$onehot0(reg_mem_ctrl[20:18]) || (reg_mem_ctrl[21] && reg_mem_ctrl[22]);
    check("ctrl_format", {24'h0, viol}, 32'h0);
  end

  // ---------------- instruction-level reference ----------------
  int         m_lat [$];
  logic [3:0] m_pc [$];
  logic [7:0] m_ac [$];
  bit         m_halt;
  logic [7:0] m_mem [16];

  task automatic model_run(input int max_instr);
    logic [3:0] p, op, ad;
    logic [7:0] a, w, opnd;
    int lat;
    m_lat.delete(); m_pc.delete(); m_ac.delete();
    m_halt = 1'b0;
    for (int i = 0; i < 16; i++) m_mem[i] = prog[i];
    p = 4'h0;
    a = 8'h00;
    for (int n = 0; n < max_instr && !m_halt; n++) begin
      w    = m_mem[p];
      p    = p + 4'h1;
      op   = w[7:4];
      ad   = w[3:0];
      opnd = m_mem[ad];
      lat  = 4;
      case (op)
        4'h0: begin a = a + opnd;           lat = 5; end
        4'h1: begin a = opnd << 1;          lat = 5; end
        4'h2: begin a = ~(a ^ opnd);        lat = 5; end
        4'h3: begin a = {opnd[7], opnd[7:1]}; lat = 5; end
        4'h4: begin a = opnd;               lat = 5; end
        4'h6: begin a = 8'h00 - opnd;       lat = 5; end
        4'h5: m_mem[ad] = a;
        4'h7: p = ad;
        4'h8: a = a + 8'h01;
        4'h9: a = 8'h00;
        4'hF: m_halt = 1'b1;
        default: ;
      endcase
      m_lat.push_back(lat);
      m_pc.push_back(p);
      m_ac.push_back(a);
    end
  endtask

  // ---------------- stimulus ----------------
  int total_cyc;

  task automatic do_reset(input int n);
    logic [7:0] exp_ir;
    rst      = 1'b1;
    run      = 1'b0;
    poke     = 1'b1;
    poke_val = 8'($urandom);
    exp_ir   = poke_val ^ 8'h5A;
    @(negedge clk);
    poke = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("rst_ctrl", reg_mem_ctrl, 24'h104920);
      check("rst_bus", bus_ctrl, 0);
      check("rst_halted", halted, 0);
      check("rst_state", state, 0);
      check("rst_count", instr_count, 0);
    end
    rst = 1'b0;
    #1;
    check("rst_ar", ar, 0);
    check("rst_pc", pc, 0);
    check("rst_dr", dr, 0);
    check("rst_ac", ac, 0);
    check("rst_tr", tr, 0);
    check("rst_ir_kept", ir, exp_ir);
  endtask

  task automatic run_prog(input int max_instr, input int stall_max, input bit rand_run);
    int st, last;
    model_run(max_instr);
    do_reset(1);
    total_cyc = 0;
    last = m_lat.size() - 1;
    for (int i = 0; i <= last; i++) begin
      check("boundary_state", state, 0);
      st = $urandom_range(stall_max, 0);
      for (int s = 0; s < st; s++) begin
        run = 1'b0;
        #1;
        check("gate_ctrl", reg_mem_ctrl, 0);
        check("gate_bus", bus_ctrl, 0);
        @(negedge clk);
        check("gate_state", state, 0);
        check("gate_count", instr_count, i % 256);
      end
      run = 1'b1;
      #1;
      check("f0_bus", bus_ctrl, 2);
      check("f0_ctrl", reg_mem_ctrl, 24'h000008);
      for (int c = 1; c <= m_lat[i]; c++) begin
        @(negedge clk);
        total_cyc++;
        if (c < m_lat[i]) begin
          check("mid_state", state, c);
          check("mid_count", instr_count, i % 256);
          check("mid_halted", halted, 0);
          if (c == 1) begin
            check("f1_bus", bus_ctrl, 7);
            check("f1_ctrl", reg_mem_ctrl, 24'h208080);
          end
          if (c == 2) begin
            check("dec_bus", bus_ctrl, 5);
            check("dec_ctrl", reg_mem_ctrl, 24'h000008);
          end
          if (c == 4) begin
            check("ex1_bus", bus_ctrl, 0);
            check("ex1_ctrl", reg_mem_ctrl, 24'h001000);
          end
          run = rand_run ? 1'($urandom) : 1'b1;
        end
      end
      check("ret_count", instr_count, (i + 1) % 256);
      check("ret_pc", pc, m_pc[i]);
      check("ret_ac", ac, m_ac[i]);
      check("ret_halted", halted, (m_halt && i == last) ? 1 : 0);
    end
    for (int k = 0; k < 16; k++) check($sformatf("mem%0d", k), mem[k], m_mem[k]);
    if (m_halt) begin
      for (int k = 0; k < 5; k++) begin
        run = 1'($urandom);
        @(negedge clk);
        check("halt_state", state, 5);
        check("halt_flag", halted, 1);
        check("halt_count", instr_count, (last + 1) % 256);
        check("halt_ctrl", reg_mem_ctrl, 0);
        check("halt_bus", bus_ctrl, 0);
      end
    end
  endtask

  task automatic clear_prog();
    for (int k = 0; k < 16; k++) prog[k] = 8'h00;
  endtask

  initial begin
    // Reset word and run gating.
    clear_prog();
    do_reset(2);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("idle_state", state, 0);
      check("idle_ctrl", reg_mem_ctrl, 0);
      check("idle_bus", bus_ctrl, 0);
      check("idle_pc", pc, 0);
    end
    run = 1'b1;
    #1;
    check("run_bus", bus_ctrl, 2);
    check("run_ar_load", reg_mem_ctrl[3], 1);

    // Program-level: LDA 9, ADD A, STA B, HLT.
    clear_prog();
    prog[0] = 8'h49; prog[1] = 8'h0A; prog[2] = 8'h5B; prog[3] = 8'hF0;
    prog[9] = 8'h05; prog[10] = 8'h03;
    run_prog(20, 0, 1'b0);
    check("prog_cycles", total_cyc, 18);
    check("prog_memB", mem[11], 8'h08);
    check("prog_count", instr_count, 4);
    check("prog_pc", pc, 4);
    check("prog_halted", halted, 1);

    // JMP, INA, INA, CLA, HLT.
    clear_prog();
    prog[0] = 8'h76; prog[6] = 8'h80; prog[7] = 8'h80; prog[8] = 8'h90; prog[9] = 8'hF0;
    run_prog(20, 1, 1'b1);
    check("jmp_count", instr_count, 5);
    check("jmp_ac", ac, 0);
    check("jmp_pc", pc, 4'hA);

    // Reset during EXEC1 of an ADD.
    clear_prog();
    prog[0] = 8'h80; prog[1] = 8'h0A; prog[10] = 8'h03;
    do_reset(1);
    run = 1'b1;
    repeat (8) @(negedge clk);
    check("mid_exec1_state", state, 4);
    check("mid_exec1_ac", ac, 1);
    check("mid_exec1_count", instr_count, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ac", ac, 0);
    check("midrst_state", state, 0);
    check("midrst_count", instr_count, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("restart_count", instr_count, 1);
    check("restart_ac", ac, 1);
    check("restart_pc", pc, 1);

    // Counter wrap with an INA/JMP loop.
    clear_prog();
    prog[0] = 8'h80; prog[1] = 8'h70;
    run_prog(510, 0, 1'b0);
    check("wrap_count", instr_count, 510 % 256);

    // NOP timing.
    clear_prog();
    prog[0] = 8'hA0; prog[1] = 8'hF0;
    run_prog(4, 0, 1'b0);
    check("nop_cycles", total_cyc, 8);

    // Random programs with random stalls and run toggling mid-instruction.
    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < 16; k++) prog[k] = 8'($urandom);
      run_prog(40, 2, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/risc_control_sequencer.md
Name: risc_control_sequencer

Overview:
- Hardwired control unit for the 8-bit accumulator datapath (AR, PC, DR, AC, IR, TR, 16x8 memory, common bus).
- Runs the fetch/decode/execute state machine from the 4-bit opcode in IR[7:4].
- Drives the 24-bit register/memory control word and the 3-bit bus select every cycle.
- Provides halt, run-gating and a retired-instruction counter for the top level.

Parameters:
- HALT_OPCODE, 4'hF, opcode that stops the machine.
- IDLE_SEL, 3'd0, bus select driven in cycles where no source is needed.

Ports:
- clk  input  1  system clock, all state changes on posedge
- rst  input  1  synchronous active-high reset
- run  input  1  1 = start the next instruction at a FETCH0 boundary; 0 = hold in FETCH0
- instruction  input  4  opcode from the datapath (IR[7:4])
- reg_mem_ctrl  output  24  control word; see bit map below
- bus_ctrl  output  3  bus source: 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM
- halted  output  1  high while in HALT
- state  output  3  current state encoding, for debug
- instr_count  output  8  retired instructions, wraps 255->0

Behaviour:
- Control word map. Each register field is {clear, inc, load}, with load at the lowest bit of the field.
  - [2:0]: unused, always 0.
  - AR [5:3], PC [8:6], DR [11:9], AC [14:12], IR [17:15] (load only), TR [20:18].
  - Memory [23:21]: [21] read, [22] write, [23] reserved 0.
- Memory contract: read is combinational from AR; write occurs at the posedge while [22]=1.
- Both outputs are combinational from state and instruction. At most one of load/inc/clear may be asserted per field.
- States: FETCH0=0, FETCH1=1, DECODE=2, EXEC0=3, EXEC1=4, HALT=5. Encodings 6 and 7 go to FETCH0.
- FETCH0:
  - If run=1: bus=PC, AR load; next state FETCH1.
  - If run=0: all controls 0, bus=IDLE_SEL; stay in FETCH0.
- FETCH1: bus=MEM, mem read, IR load, PC inc; next DECODE.
- DECODE: bus=IR, AR load (AR takes bus[3:0]); next EXEC0.
- EXEC0, by opcode:
  - 0000 ADD, 0001 ASL, 0010 XNR, 0011 ASR, 0100 LDA, 0110 NEG: bus=MEM, mem read, DR load; next EXEC1.
  - 0101 STA: bus=AC, mem write; done.
  - 0111 JMP: bus=AR, PC load; done.
  - 1000 INA: AC inc; done.
  - 1001 CLA: AC clear; done.
  - HALT_OPCODE: no controls asserted; next HALT, and counts as retired.
  - Other 1xxx: NOP; done.
- EXEC1: AC load (ALU result selected by IR[6:4]); bus=IDLE_SEL; done.
- "done" means: next state FETCH0, and instr_count increments on the same edge.
- HALT: all controls 0, bus=IDLE_SEL, halted=1. Only rst exits HALT; run is ignored.
- Latencies: LDA and ALU ops 5 cycles; STA, JMP, INA, CLA, NOP 4 cycles; HLT reaches HALT after 4 cycles.
- Reset, while rst=1:
  - reg_mem_ctrl=24'h104920 (clear AR, PC, DR, AC, TR), bus_ctrl=IDLE_SEL, halted=0.
  - On the edge: state=FETCH0, instr_count=0.
  - rst overrides every state, including mid-instruction and HALT.
  - IR is not cleared; the decode-dependent output is harmless because FETCH0 ignores instruction.
- run is sampled only in FETCH0. Dropping run mid-instruction does not stop that instruction.
- instr_count wraps 8'hFF->8'h00 without a flag.

Test Plan:
- Program-level check.
  - Stimulus: memory {0:0x49, 1:0x0A, 2:0x5B, 3:0xF0, 9:0x05, A:0x03}, rst 1 cycle, run=1.
  - Required: mem[B]=0x08, halted=1 exactly 18 cycles after reset release, instr_count=4, PC=4.
- Reset control word: rst high for 2 cycles -> reg_mem_ctrl=24'h104920, bus_ctrl=0, state=0; AR, PC, DR, AC, TR read 0 after release.
- run gating: run=0 after reset for 10 cycles -> state stays 0, all controls 0, PC unchanged; raise run -> FETCH0 asserts bus_ctrl=2, reg_mem_ctrl[3]=1.
- JMP and INA/CLA.
  - Stimulus: mem {0:0x76, 6:0x80, 7:0x80, 8:0x90, 9:0xF0}.
  - Required: PC jumps to 6, AC=2 after the INAs, AC=0 after CLA, halted after instr_count=5.
- Reset mid-instruction: assert rst during EXEC1 of an ADD -> AC not loaded, state=FETCH0 next cycle, instr_count=0; after release, execution restarts from address 0.
- Counter wrap: loop program {0:0x80, 1:0x70} run 510 instructions -> instr_count reaches 0xFF then reads 0x00 on the next retire; NOP opcode 0xA0 retires in 4 cycles.
